// File: rtl/ecc_job_sched.sv
// ecc_job_sched
// Takes ECC job descriptors from two requesters with round-robin arbitration,
// programs the ECC register bank over APB, waits for operation_done (with a
// watchdog), and returns the result on a valid/ready response channel.

module ecc_job_sched #(
   parameter int                         AMBA_WORD       = 32,
   parameter int                         AMBA_ADDR_WIDTH = 20,
   parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL       = 'h0,
   parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN    = 'h4,
   parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW_WIDTH   = 'h8,
   parameter logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE      = 'hC,
   parameter int                         TIMEOUT_CYCLES  = 16
) (
   input  logic                       clk,
   input  logic                       rst,

   // Job request channel, one lane per requester ({req1, req0})
   input  logic [1:0]                 req_valid,
   output logic [1:0]                 req_ready,
   input  logic [3:0]                 req_mode,
   input  logic [3:0]                 req_width,
   input  logic [2*AMBA_WORD-1:0]     req_data,
   input  logic [2*AMBA_WORD-1:0]     req_noise,

   // APB master towards the ECC register bank
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,

   // ECC top result
   input  logic [AMBA_WORD-1:0]       ecc_data_out,
   input  logic                       ecc_operation_done,
   input  logic [1:0]                 ecc_num_of_errors,

   // Response channel
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_id,
   output logic [AMBA_WORD-1:0]       rsp_data,
   output logic [1:0]                 rsp_num_errors,
   output logic [1:0]                 rsp_status,

   output logic                       busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] MODE_FC      = 2'd2;
   localparam logic [1:0] MODE_ILLEGAL = 2'd3;

   localparam logic [1:0] STATUS_OK      = 2'd0;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
   localparam logic [1:0] STATUS_ILLEGAL = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   // Register written by the current APB transfer
   typedef enum logic [1:0] {
      W_DATA,
      W_WIDTH,
      W_NOISE,
      W_CTRL
   } widx_t;

   state_t           state;
   widx_t            widx;
   widx_t            next_widx;
   logic             rr_ptr;
   logic             grant_id;
   logic             any_valid;
   logic [1:0]       sel_mode;
   logic [1:0]       sel_width;
   logic [AMBA_WORD-1:0] sel_data;
   logic [AMBA_WORD-1:0] sel_noise;

   // Latched descriptor. DATA_IN is written in the very first transfer and is
   // loaded straight into PWDATA at accept, so it needs no copy here.
   logic             job_id;
   logic [1:0]       job_mode;
   logic [1:0]       job_width;
   logic [AMBA_WORD-1:0] job_noise;
   logic [CNT_W-1:0] wd_cnt;

   // Round-robin pick and descriptor mux: the pointed-at requester wins if
   // valid, otherwise the other one.
   // NOTE: every signal gets a default at the top of always_comb so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      any_valid = |req_valid;
      grant_id  = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
      req_ready = 2'b00;
      if (state == S_IDLE && any_valid) begin
         req_ready[grant_id] = 1'b1;
      end
      sel_mode  = grant_id ? req_mode[3:2]                 : req_mode[1:0];
      sel_width = grant_id ? req_width[3:2]                : req_width[1:0];
      sel_data  = grant_id ? req_data[2*AMBA_WORD-1:AMBA_WORD]  : req_data[AMBA_WORD-1:0];
      sel_noise = grant_id ? req_noise[2*AMBA_WORD-1:AMBA_WORD] : req_noise[AMBA_WORD-1:0];
   end

   // Next register to program: NOISE is skipped unless the job is FC, and
   // CTRL is always last because writing it starts the ECC operation.
   always_comb begin
      next_widx = W_CTRL;
      case (widx)
         W_DATA:  next_widx = W_WIDTH;
         W_WIDTH: next_widx = (job_mode == MODE_FC) ? W_NOISE : W_CTRL;
         W_NOISE: next_widx = W_CTRL;
         default: next_widx = W_CTRL;
      endcase
   end

   function automatic logic [AMBA_ADDR_WIDTH-1:0] apb_addr(input widx_t idx);
      case (idx)
         W_DATA:  return ADDR_DATA_IN;
         W_WIDTH: return ADDR_CW_WIDTH;
         W_NOISE: return ADDR_NOISE;
         default: return ADDR_CTRL;
      endcase
   endfunction

   function automatic logic [AMBA_WORD-1:0] apb_wdata(input widx_t idx);
      case (idx)
         W_WIDTH: return {{(AMBA_WORD-2){1'b0}}, job_width};
         W_NOISE: return job_noise;
         W_CTRL:  return {{(AMBA_WORD-2){1'b0}}, job_mode};
         default: return '0;
      endcase
   endfunction

   // Main scheduler FSM: accept, APB write sequence, wait for done, respond.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         widx           <= W_DATA;
         rr_ptr         <= 1'b0;
         job_id         <= 1'b0;
         job_mode       <= 2'd0;
         job_width      <= 2'd0;
         job_noise      <= '0;
         wd_cnt         <= '0;
         PADDR          <= '0;
         PWDATA         <= '0;
         PSEL           <= 1'b0;
         PENABLE        <= 1'b0;
         PWRITE         <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_id         <= 1'b0;
         rsp_data       <= '0;
         rsp_num_errors <= 2'd0;
         rsp_status     <= STATUS_OK;
         busy           <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  job_id    <= grant_id;
                  job_mode  <= sel_mode;
                  job_width <= sel_width;
                  job_noise <= sel_noise;
                  rr_ptr    <= ~grant_id;
                  busy      <= 1'b1;
                  if (sel_mode == MODE_ILLEGAL) begin
                     // Rejected without touching the ECC block
                     rsp_valid      <= 1'b1;
                     rsp_id         <= grant_id;
                     rsp_data       <= '0;
                     rsp_num_errors <= 2'd0;
                     rsp_status     <= STATUS_ILLEGAL;
                     state          <= S_RESP;
                  end else begin
                     widx    <= W_DATA;
                     PADDR   <= ADDR_DATA_IN;
                     PWDATA  <= sel_data;
                     PSEL    <= 1'b1;
                     PENABLE <= 1'b0;
                     PWRITE  <= 1'b1;
                     state   <= S_SETUP;
                  end
               end
            end

            S_SETUP: begin
               PENABLE <= 1'b1;
               state   <= S_ACCESS;
            end

            S_ACCESS: begin
               if (widx == W_CTRL) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  PWRITE  <= 1'b0;
                  wd_cnt  <= '0;
                  state   <= S_WAIT_DONE;
               end else begin
                  widx    <= next_widx;
                  PADDR   <= apb_addr(next_widx);
                  PWDATA  <= apb_wdata(next_widx);
                  PENABLE <= 1'b0;
                  state   <= S_SETUP;
               end
            end

            S_WAIT_DONE: begin
               // Done is checked first so it wins over a same-cycle timeout
               if (ecc_operation_done) begin
                  rsp_valid      <= 1'b1;
                  rsp_id         <= job_id;
                  rsp_data       <= ecc_data_out;
                  rsp_num_errors <= ecc_num_of_errors;
                  rsp_status     <= STATUS_OK;
                  state          <= S_RESP;
               end else if (wd_cnt == WD_LAST) begin
                  rsp_valid      <= 1'b1;
                  rsp_id         <= job_id;
                  rsp_data       <= '0;
                  rsp_num_errors <= 2'd0;
                  rsp_status     <= STATUS_TIMEOUT;
                  state          <= S_RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_job_sched.sv
// Testbench for ecc_job_sched: directed scenarios plus randomized jobs, each
// compared against a transaction-level model of the scheduler's behaviour.

module tb_ecc_job_sched;

   localparam int W  = 32;
   localparam int AW = 20;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [3:0]      req_mode;
   logic [3:0]      req_width;
   logic [2*W-1:0]  req_data;
   logic [2*W-1:0]  req_noise;
   logic [AW-1:0]   PADDR;
   logic [W-1:0]    PWDATA;
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [W-1:0]    ecc_data_out;
   logic            ecc_operation_done;
   logic [1:0]      ecc_num_of_errors;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_id;
   logic [W-1:0]    rsp_data;
   logic [1:0]      rsp_num_errors;
   logic [1:0]      rsp_status;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;
   int mptr        = 0;   // model round-robin pointer

   typedef struct {
      logic [1:0]   mode;
      logic [1:0]   width;
      logic [W-1:0] data;
      logic [W-1:0] noise;
   } desc_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } wr_t;

   desc_t d[2];

   always #5 clk = ~clk;

   ecc_job_sched #(
      .AMBA_WORD       (W),
      .AMBA_ADDR_WIDTH (AW),
      .ADDR_CTRL       (20'h0),
      .ADDR_DATA_IN    (20'h4),
      .ADDR_CW_WIDTH   (20'h8),
      .ADDR_NOISE      (20'hC),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_mode           (req_mode),
      .req_width          (req_width),
      .req_data           (req_data),
      .req_noise          (req_noise),
      .PADDR              (PADDR),
      .PWDATA             (PWDATA),
      .PSEL               (PSEL),
      .PENABLE            (PENABLE),
      .PWRITE             (PWRITE),
      .ecc_data_out       (ecc_data_out),
      .ecc_operation_done (ecc_operation_done),
      .ecc_num_of_errors  (ecc_num_of_errors),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_id             (rsp_id),
      .rsp_data           (rsp_data),
      .rsp_num_errors     (rsp_num_errors),
      .rsp_status         (rsp_status),
      .busy               (busy)
   );

   function automatic wr_t mk_wr(input logic [AW-1:0] a, input logic [W-1:0] v);
      wr_t e;
      e.addr = a;
      e.data = v;
      return e;
   endfunction

   task automatic drive_desc();
      req_mode  = {d[1].mode,  d[0].mode};
      req_width = {d[1].width, d[0].width};
      req_data  = {d[1].data,  d[0].data};
      req_noise = {d[1].noise, d[0].noise};
   endtask

   // One complete job. Called and returns at a falling edge.
   // done_wait: WAIT_DONE cycle index (0 = first) where done is driven; <0 = never.
   task automatic run_job(input logic [1:0] valid, input int done_wait,
                          input logic [W-1:0] dout, input logic [1:0] nerr,
                          input int ready_delay, input bit keep);
      int            g;
      desc_t         jd;
      wr_t           exp_q[$];
      wr_t           got_q[$];
      int            nw;
      int            exp_lat;
      int            exp_waits;
      logic [1:0]    exp_status;
      logic [W-1:0]  exp_data;
      logic [1:0]    exp_err;
      logic [1:0]    exp_rdy;
      int            c;
      int            wcount;
      bit            waiting;
      bit            in_setup;
      bit            proto_ok;
      bit            ready_ok;
      bit            stable_ok;
      bit            writes_ok;
      bit            seen;
      logic          drv_done;
      logic [AW-1:0] s_addr;
      logic [W-1:0]  s_data;
      logic          snap_id;
      logic [W-1:0]  snap_data;
      logic [1:0]    snap_err;
      logic [1:0]    snap_status;

      // Reference model for this job
      g       = valid[mptr] ? mptr : 1 - mptr;
      jd      = d[g];
      exp_rdy = (g == 0) ? 2'b01 : 2'b10;
      if (jd.mode != 2'd3) begin
         exp_q.push_back(mk_wr(20'h4, jd.data));
         exp_q.push_back(mk_wr(20'h8, {30'd0, jd.width}));
         if (jd.mode == 2'd2) exp_q.push_back(mk_wr(20'hC, jd.noise));
         exp_q.push_back(mk_wr(20'h0, {30'd0, jd.mode}));
      end
      nw = exp_q.size();
      if (jd.mode == 2'd3) begin
         exp_status = 2'd2; exp_data = '0;   exp_err = 2'd0;
         exp_lat    = 1;    exp_waits = 0;
      end else if (done_wait >= 0 && done_wait < TO) begin
         exp_status = 2'd0; exp_data = dout; exp_err = nerr;
         exp_lat    = 2 * nw + done_wait + 2; exp_waits = done_wait + 1;
      end else begin
         exp_status = 2'd1; exp_data = '0;   exp_err = 2'd0;
         exp_lat    = 2 * nw + TO + 1;       exp_waits = TO;
      end

      drive_desc();
      req_valid          = valid;
      ecc_data_out       = dout;
      ecc_num_of_errors  = nerr;
      ecc_operation_done = 1'b0;
      #1;
      vectors++;
      if (req_ready !== exp_rdy) begin
         miscompares++;
         $display("FAIL grant_ready: got %b expected %b", req_ready, exp_rdy);
      end
      @(posedge clk);
      mptr = 1 - g;

      c = 0; wcount = 0; waiting = 0; in_setup = 0;
      proto_ok = 1; ready_ok = 1; seen = 0;
      s_addr = '0; s_data = '0;
      while (c < 200) begin
         @(negedge clk);
         c++;
         if (!keep) req_valid = 2'b00;
         if (req_ready !== 2'b00 || busy !== 1'b1) ready_ok = 0;
         if (rsp_valid === 1'b1) begin
            seen = 1;
            break;
         end
         drv_done = 1'b0;
         if (PSEL === 1'b1 && PENABLE === 1'b0) begin
            in_setup = 1; s_addr = PADDR; s_data = PWDATA;
            if (PWRITE !== 1'b1) proto_ok = 0;
            drv_done = ($urandom_range(0, 3) == 0);   // must be ignored here
         end else if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            if (!in_setup || PADDR !== s_addr || PWDATA !== s_data || PWRITE !== 1'b1)
               proto_ok = 0;
            in_setup = 0;
            got_q.push_back(mk_wr(PADDR, PWDATA));
            if (got_q.size() == nw) waiting = 1;
            drv_done = ($urandom_range(0, 3) == 0);
         end else begin
            if (PENABLE !== 1'b0) proto_ok = 0;
            if (waiting) begin
               drv_done = (wcount == done_wait);
               wcount++;
            end
         end
         ecc_operation_done = drv_done;
      end
      ecc_operation_done = 1'b0;

      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL rsp_valid_wait: no response after %0d cycles, expected at %0d", c, exp_lat);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         return;
      end

      vectors++;
      if (c != exp_lat) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles expected %0d", c, exp_lat);
      end
      vectors++;
      if (rsp_id !== 1'(g)) begin
         miscompares++;
         $display("FAIL rsp_id: got %0d expected %0d", rsp_id, g);
      end
      vectors++;
      if (rsp_status !== exp_status) begin
         miscompares++;
         $display("FAIL rsp_status: got %0d expected %0d", rsp_status, exp_status);
      end
      vectors++;
      if (rsp_data !== exp_data) begin
         miscompares++;
         $display("FAIL rsp_data: got %h expected %h", rsp_data, exp_data);
      end
      vectors++;
      if (rsp_num_errors !== exp_err) begin
         miscompares++;
         $display("FAIL rsp_num_errors: got %0d expected %0d", rsp_num_errors, exp_err);
      end
      writes_ok = (got_q.size() == nw);
      if (writes_ok) begin
         for (int i = 0; i < nw; i++) begin
            if (got_q[i].addr !== exp_q[i].addr || got_q[i].data !== exp_q[i].data) writes_ok = 0;
         end
      end
      vectors++;
      if (!writes_ok) begin
         miscompares++;
         $display("FAIL apb_writes: got %0d writes expected %0d (mode %0d)", got_q.size(), nw, jd.mode);
      end
      vectors++;
      if (!proto_ok) begin
         miscompares++;
         $display("FAIL apb_protocol: got bad SETUP/ACCESS pairing expected stable two-phase writes");
      end
      vectors++;
      if (!ready_ok) begin
         miscompares++;
         $display("FAIL busy_ready: got req_ready set or busy low during job, expected 0/1");
      end
      vectors++;
      if (wcount != exp_waits) begin
         miscompares++;
         $display("FAIL wait_cycles: got %0d expected %0d", wcount, exp_waits);
      end

      // Backpressure: payload must hold while rsp_ready is low
      snap_id = rsp_id; snap_data = rsp_data; snap_err = rsp_num_errors; snap_status = rsp_status;
      stable_ok = 1;
      for (int i = 0; i < ready_delay; i++) begin
         rsp_ready          = 1'b0;
         ecc_operation_done = ($urandom_range(0, 1) == 1);
         ecc_data_out       = $urandom;
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_id !== snap_id || rsp_data !== snap_data ||
             rsp_num_errors !== snap_err || rsp_status !== snap_status ||
             req_ready !== 2'b00 || PSEL !== 1'b0 || busy !== 1'b1)
            stable_ok = 0;
      end
      ecc_operation_done = 1'b0;
      ecc_data_out       = dout;
      vectors++;
      if (!stable_ok) begin
         miscompares++;
         $display("FAIL rsp_hold: got payload/ready change during backpressure, expected stable");
      end

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rsp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== '0 || PWDATA !== '0) begin
         miscompares++;
         $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b addr=%h data=%h expected all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA);
      end
      vectors++;
      if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== '0 ||
          rsp_num_errors !== 2'd0 || rsp_status !== 2'd0 || busy !== 1'b0 || req_ready !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_rsp: got valid=%b id=%b data=%h err=%0d st=%0d busy=%b rdy=%b expected all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_num_errors, rsp_status, busy, req_ready);
      end
      rst = 1'b0;
      mptr = 0;
      @(negedge clk);
   endtask

   task automatic test_single_eo();
      d[0] = '{2'd0, 2'd1, 32'h0000_00AB, $urandom};
      d[1] = '{2'd0, 2'd0, 32'h0, 32'h0};
      run_job(2'b01, 2, 32'h1234, 2'd0, 0, 0);
   endtask

   task automatic test_fc();
      d[1] = '{2'd2, 2'd2, $urandom, 32'h0000_0010};
      run_job(2'b10, 2, $urandom, 2'd1, 1, 0);
   endtask

   task automatic test_round_robin();
      d[0] = '{2'd1, 2'd0, 32'hA5A5_0000, 32'h0};
      d[1] = '{2'd0, 2'd2, 32'h0000_5A5A, 32'h0};
      for (int i = 0; i < 4; i++) begin
         run_job(2'b11, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 0, 1);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_timeout();
      d[0] = '{2'd0, 2'd2, 32'h1111_2222, 32'h0};
      run_job(2'b01, -1, 32'hDEAD_BEEF, 2'd2, 0, 0);
      // done arriving on the last watchdog cycle still wins
      d[1] = '{2'd1, 2'd0, 32'h3333_4444, 32'h0};
      run_job(2'b10, TO - 1, 32'hFEED_F00D, 2'd3, 0, 0);
   endtask

   task automatic test_illegal_backpressure();
      d[0] = '{2'd3, 2'd1, 32'h7777_7777, 32'h8888_8888};
      run_job(2'b01, 0, 32'h9999_9999, 2'd1, 5, 0);
   endtask

   task automatic test_reset_mid_job();
      bit quiet;
      d[0] = '{2'd1, 2'd2, 32'hCAFE_0001, 32'h0};
      drive_desc();
      req_valid = 2'b01;
      @(posedge clk);
      mptr = 1;
      @(negedge clk);              // cycle 1: DATA_IN SETUP
      req_valid = 2'b00;
      repeat (3) @(negedge clk);   // cycle 4: CODEWORD_WIDTH ACCESS
      vectors++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 20'h8) begin
         miscompares++;
         $display("FAIL midjob_access: got psel=%b pen=%b addr=%h expected 1 1 8", PSEL, PENABLE, PADDR);
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got psel=%b pen=%b busy=%b valid=%b expected 0 0 0 0",
                  PSEL, PENABLE, busy, rsp_valid);
      end
      @(negedge clk);
      rst  = 1'b0;
      mptr = 0;
      quiet = 1;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || busy !== 1'b0) quiet = 0;
      end
      vectors++;
      if (!quiet) begin
         miscompares++;
         $display("FAIL post_reset_quiet: got activity after reset, expected none");
      end
      d[1] = '{2'd0, 2'd0, 32'h0000_0042, 32'h0};
      run_job(2'b11, 1, 32'h0000_55AA, 2'd0, 0, 0);
   endtask

   task automatic test_random();
      int dw;
      int r;
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 2; k++) begin
            d[k].mode  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            d[k].width = 2'($urandom_range(0, 2));
            d[k].data  = $urandom;
            d[k].noise = $urandom;
         end
         r = $urandom_range(0, 9);
         if (r == 0)      dw = -1;
         else if (r == 1) dw = TO - 1;
         else             dw = $urandom_range(0, 6);
         run_job(2'($urandom_range(1, 3)), dw, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst                = 1'b1;
      req_valid          = 2'b00;
      req_mode           = '0;
      req_width          = '0;
      req_data           = '0;
      req_noise          = '0;
      ecc_data_out       = '0;
      ecc_operation_done = 1'b0;
      ecc_num_of_errors  = 2'd0;
      rsp_ready          = 1'b0;
      d[0] = '{2'd0, 2'd0, 32'h0, 32'h0};
      d[1] = '{2'd0, 2'd0, 32'h0, 32'h0};

      test_reset();
      test_single_eo();
      test_fc();
      test_round_robin();
      test_timeout();
      test_illegal_backpressure();
      test_reset_mid_job();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ecc_job_sched.md
# ecc_job_sched

Job scheduler and APB master for the ECC encoder/decoder top. It takes ECC job descriptors from two requesters and arbitrates between them round-robin. For each granted job it programs the ECC register bank over APB, then waits for `operation_done`. It returns `data_out` and `num_of_errors` to the winning requester through a valid/ready response channel, with a watchdog for jobs that never complete.

## Interface
- `AMBA_WORD`, 32, APB data width and descriptor word width
- `AMBA_ADDR_WIDTH`, 20, APB address width
- `ADDR_CTRL`, 'h0, CTRL register address; writing it starts the ECC operation
- `ADDR_DATA_IN`, 'h4, DATA_IN register address
- `ADDR_CW_WIDTH`, 'h8, CODEWORD_WIDTH register address
- `ADDR_NOISE`, 'hC, NOISE register address
- `TIMEOUT_CYCLES`, 16, maximum WAIT_DONE cycles before the job is aborted (≥ 8)

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `req_valid` in 2 — per-requester job valid
- `req_ready` out 2 — per-requester accept (one-hot or zero)
- `req_mode` in 4 — {req1, req0} mode: 0 = EO, 1 = DO, 2 = FC, 3 = illegal
- `req_width` in 4 — {req1, req0} codeword width code: 0 = 8, 1 = 16, 2 = 32
- `req_data` in 2*AMBA_WORD — {req1, req0} DATA_IN values
- `req_noise` in 2*AMBA_WORD — {req1, req0} NOISE values
- `PADDR` out AMBA_ADDR_WIDTH — APB address
- `PWDATA` out AMBA_WORD — APB write data
- `PSEL`, `PENABLE`, `PWRITE` out 1 each — APB control
- `ecc_data_out` in AMBA_WORD — ECC top `data_out`
- `ecc_operation_done` in 1 — ECC top done pulse
- `ecc_num_of_errors` in 2 — ECC top error count
- `rsp_valid` out 1; `rsp_ready` in 1 — response handshake
- `rsp_id` out 1 — index of the requester that owns the response
- `rsp_data` out AMBA_WORD — captured `data_out`
- `rsp_num_errors` out 2 — captured `num_of_errors`
- `rsp_status` out 2 — 0 = OK, 1 = timeout, 2 = illegal mode
- `busy` out 1 — high in every state except IDLE

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- **IDLE**
  - Winner g is the valid requester nearest the round-robin pointer; the pointer resets to 0.
  - `req_ready[g]` is asserted combinationally whenever any `req_valid` is high.
  - On handshake: latch the descriptor and g, set pointer = ~g.
  - Mode 3 goes directly to RESP with status 2. Otherwise go to SETUP with write index 0.
- **Write sequence**
  - Order: DATA_IN, CODEWORD_WIDTH (`req_width` zero-extended), NOISE (FC only), CTRL (mode zero-extended).
  - CTRL is always the last write.
  - Each write is SETUP (PSEL=1, PENABLE=0) followed by ACCESS (PSEL=1, PENABLE=1).
  - PWRITE=1, PADDR and PWDATA are stable across both cycles. No wait states.
  - ACCESS goes to SETUP for the next write, or to WAIT_DONE after the CTRL write.
- **WAIT_DONE**
  - Watchdog counter starts at 0 on entry and increments every cycle.
  - First cycle with `ecc_operation_done`=1: capture `ecc_data_out` and `ecc_num_of_errors`, status 0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: `rsp_data`=0, errors=0, status 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `rsp_valid` is held with stable payload until `rsp_ready`. Handshake returns to IDLE.
  - No new job is accepted before the handshake completes.
- `ecc_operation_done` is ignored outside WAIT_DONE.
- Reset values: all outputs 0, state IDLE, pointer 0, captured payload 0.
- Asynchronous reset mid-job: PSEL and PENABLE drop immediately, the job is discarded, and no response is issued.

## Timing
- Cycle 0 is the accept edge. SETUP of DATA_IN is in cycle 1.
- CTRL ACCESS is in cycle 6 for EO/DO and cycle 8 for FC. WAIT_DONE begins the following cycle.
- Capture happens in the done cycle. `rsp_valid` is asserted in the next cycle.
- Best case from accept to `rsp_valid`, for an ECC done 3 cycles after the CTRL write: 10 cycles EO/DO, 12 cycles FC.
- Illegal mode: `rsp_valid` one cycle after accept, with no APB activity.
- `rsp_ready` held high: IDLE is re-entered one cycle after `rsp_valid`, and the next accept can occur in that IDLE cycle.

## Test plan
- **Single EO job:** req0, mode 0, width 1, data 'h00AB, done 3 cycles after CTRL, `ecc_data_out`='h1234 -> APB writes 0x4='h00AB, 0x8=1, 0x0=0 (no NOISE write); response id 0, data 'h1234, status 0.
- **FC job:** req1, mode 2, noise 'h0000_0010, errors=1 -> four writes with NOISE at 0xC before CTRL=2; `rsp_num_errors`=1, `rsp_id`=1.
- **Round-robin:** both requesters continuously valid for 4 jobs -> grants alternate 0,1,0,1; `req_ready` never has both bits high.
- **Timeout:** done never asserted, TIMEOUT_CYCLES=16 -> response status 1, data 0, exactly 16 WAIT_DONE cycles.
- **Illegal mode and backpressure:** req0 mode 3 with `rsp_ready` low for 5 cycles -> no APB activity, status 2; payload stable and `req_ready`=0 throughout.
- **Reset mid-job:** `rst` pulsed during the CODEWORD_WIDTH ACCESS -> PSEL and PENABLE go to 0 asynchronously, `busy`=0, no response; the next job is granted to req0.
